// File: rtl/modadd_sequencer_pkg.sv
// Shared definitions for the modadd sequencer: command opcodes, FSM states,
// default sizes and the BLS12-381 base-field modulus.
package modadd_sequencer_pkg;

  localparam int WIDTH_DEF          = 381;
  localparam int REGS_DEF           = 4;
  localparam int ADDR_W_DEF         = 2;
  localparam int TIMEOUT_CYCLES_DEF = 64;

  localparam logic [380:0] BLS12_381_P =
    381'h1a0111ea397fe69a4b1ba7b6434bacd764774b84f38512bf6730d2a0f6b0f6241eabfffeb153ffffb9feffffffffaaab;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_LOAD = 2'b10,
    OP_READ = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_e;

endpackage

// File: rtl/modadd_sequencer_if.sv
// Command/response bus plus the modadder-facing signals of the sequencer.
// slave = sequencer view; master = upstream controller and modadder view.
interface modadd_sequencer_if #(
  parameter int WIDTH  = 381,
  parameter int ADDR_W = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_dst;
  logic [ADDR_W-1:0] cmd_src_a;
  logic [ADDR_W-1:0] cmd_src_b;
  logic [WIDTH-1:0]  cmd_data;
  logic [WIDTH-1:0]  modulus;
  logic              rsp_valid;
  logic [WIDTH-1:0]  rsp_data;
  logic              err;
  logic              ma_start;
  logic              ma_subtract;
  logic [WIDTH-1:0]  ma_in_a;
  logic [WIDTH-1:0]  ma_in_b;
  logic [WIDTH-1:0]  ma_in_m;
  logic              ma_out_read;
  logic [WIDTH-1:0]  ma_result;
  logic              ma_done;

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_data, modulus,
           ma_result, ma_done,
    output cmd_ready, rsp_valid, rsp_data, err,
           ma_start, ma_subtract, ma_in_a, ma_in_b, ma_in_m, ma_out_read
  );

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_data, modulus,
           ma_result, ma_done,
    input  cmd_ready, rsp_valid, rsp_data, err,
           ma_start, ma_subtract, ma_in_a, ma_in_b, ma_in_m, ma_out_read
  );
endinterface

// File: rtl/modadd_regfile.sv
// Field-element register file: one write port, two asynchronous read ports,
// every entry cleared by synchronous reset.
module modadd_regfile #(
  parameter int WIDTH  = 381,
  parameter int REGS   = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  input  logic [ADDR_W-1:0] raddr_a_i,
  output logic [WIDTH-1:0]  rdata_a_o,
  input  logic [ADDR_W-1:0] raddr_b_i,
  output logic [WIDTH-1:0]  rdata_b_o
);

  logic [WIDTH-1:0] mem_q [REGS];

  // NOTE: the storage is cleared on reset because software may READ or ADD
  // from a register it never loaded and must see 0; non-blocking (<=) keeps
  // every flop updating from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/modadd_sequencer.sv
// Command sequencer feeding a modadder: LOAD/READ the register file, issue
// ADD/SUB and write the result back. Optional watchdog: MODADD_SEQ_TIMEOUT_EN.
module modadd_sequencer
  import modadd_sequencer_pkg::*;
#(
  parameter int WIDTH          = WIDTH_DEF,
  parameter int REGS           = REGS_DEF,
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic              clk,
  input logic              reset,
  modadd_sequencer_if.slave bus
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, m_q, m_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic              sub_q, sub_d;
  logic              rsp_read_q, rsp_read_d;
  logic [ADDR_W-1:0] dst_q, dst_d;

  logic              accept;
  logic              ack_rsp;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [WIDTH-1:0]  rf_wdata, rf_rdata_a, rf_rdata_b;

`ifdef MODADD_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             tmo_q, tmo_d;
`endif

  modadd_regfile #(.WIDTH(WIDTH), .REGS(REGS), .ADDR_W(ADDR_W)) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata),
    .raddr_a_i (bus.cmd_src_a),
    .rdata_a_o (rf_rdata_a),
    .raddr_b_i (bus.cmd_src_b),
    .rdata_b_o (rf_rdata_b)
  );

  assign accept = bus.cmd_valid && (state_q == S_IDLE);

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    m_d        = m_q;
    sub_d      = sub_q;
    dst_d      = dst_q;
    rsp_data_d = rsp_data_q;
    rsp_read_d = 1'b0;
    rf_we      = 1'b0;
    rf_waddr   = dst_q;
    rf_wdata   = bus.ma_result;
`ifdef MODADD_SEQ_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
    tmo_d      = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op_e'(bus.cmd_op))
            OP_LOAD: begin
              rf_we    = 1'b1;
              rf_waddr = bus.cmd_dst;
              rf_wdata = bus.cmd_data;
            end
            OP_READ: begin
              rsp_data_d = rf_rdata_a;
              rsp_read_d = 1'b1;
            end
            default: begin
              // Operands are captured here, so dst aliasing a source is harmless.
              a_d     = rf_rdata_a;
              b_d     = rf_rdata_b;
              m_d     = bus.modulus;
              sub_d   = (op_e'(bus.cmd_op) == OP_SUB);
              dst_d   = bus.cmd_dst;
              state_d = S_ISSUE;
            end
          endcase
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef MODADD_SEQ_TIMEOUT_EN
        cnt_d   = '0;
        tmo_d   = 1'b0;
`endif
      end
      S_WAIT: begin
        if (bus.ma_done) begin
          rf_we      = 1'b1;
          rsp_data_d = bus.ma_result;
          state_d    = S_ACK;
        end
`ifdef MODADD_SEQ_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      m_q        <= '0;
      sub_q      <= 1'b0;
      dst_q      <= '0;
      rsp_data_q <= '0;
      rsp_read_q <= 1'b0;
`ifdef MODADD_SEQ_TIMEOUT_EN
      cnt_q      <= '0;
      err_q      <= 1'b0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      m_q        <= m_d;
      sub_q      <= sub_d;
      dst_q      <= dst_d;
      rsp_data_q <= rsp_data_d;
      rsp_read_q <= rsp_read_d;
`ifdef MODADD_SEQ_TIMEOUT_EN
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

`ifdef MODADD_SEQ_TIMEOUT_EN
  assign ack_rsp = !tmo_q;
  assign bus.err = err_q;
`else
  assign ack_rsp = 1'b1;
  assign bus.err = 1'b0;
`endif

  assign bus.cmd_ready   = (state_q == S_IDLE);
  assign bus.ma_start    = (state_q == S_ISSUE);
  assign bus.ma_out_read = (state_q == S_ACK);
  assign bus.rsp_valid   = rsp_read_q || ((state_q == S_ACK) && ack_rsp);
  assign bus.rsp_data    = rsp_data_q;
  assign bus.ma_subtract = sub_q;
  assign bus.ma_in_a     = a_q;
  assign bus.ma_in_b     = b_q;
  assign bus.ma_in_m     = m_q;

endmodule
